// File: rtl/icache_assoc.sv
// Two-way set-associative instruction cache with halfword-granular fetch and
// a burst line-refill engine that reads whole lines from the memory controller.
//
// state    | meaning
// S_IDLE   | waiting for a fetch; hits answer directly from here
// S_REFILL | streaming one line into the victim way, one word per mem_rdata_valid
// S_LOOKUP | re-checking the captured PC after a refill (second line of a straddle)
module icache_assoc #(
    parameter int SET_BIT  = 4,
    parameter int LINE_BIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        resp_is_c,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_BIT  = 32 - SET_BIT - LINE_BIT;
    localparam int SETS     = 1 << SET_BIT;
    localparam int BEAT_BIT = LINE_BIT - 2;
    localparam int BEATS    = 1 << BEAT_BIT;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_LOOKUP} state_t;

    state_t r_state, w_state_nxt;

    logic [SETS-1:0]    r_valid [2];
    logic [TAG_BIT-1:0] r_tag   [2][SETS];
    logic [31:0]        r_data  [2][SETS][BEATS];
    logic [SETS-1:0]    r_lru;

    logic [31:0]          r_addr;
    logic [31-LINE_BIT:0] r_line;
    logic [BEAT_BIT-1:0]  r_beat;
    logic                 r_victim;
    logic                 r_drop;
    logic                 r_resp_q;
    logic [31:0]          r_resp_inst;
    logic                 r_resp_is_c;

    logic [31:0]          w_addr0, w_addr1, w_word0, w_word1;
    logic [SET_BIT-1:0]   w_set0, w_set1, w_miss_set, w_ref_set;
    logic [TAG_BIT-1:0]   w_tag0, w_tag1, w_ref_tag;
    logic [1:0]           w_hitv0, w_hitv1;
    logic                 w_way0, w_way1, w_hit0, w_hit1, w_need1, w_hit;
    logic [15:0]          w_h0, w_h1;
    logic [31-LINE_BIT:0] w_miss_line;
    logic                 w_victim, w_beat_en, w_last, w_accept;
    logic                 w_respond, w_start_refill;
    logic                 w_unused;

    // h0 at the PC, h1 at PC+2, which may fall into the next line
    assign w_addr0 = (r_state == S_IDLE) ? req_addr : r_addr;
    assign w_addr1 = w_addr0 + 32'd2;

    assign w_set0     = w_addr0[LINE_BIT +: SET_BIT];
    assign w_tag0     = w_addr0[31 -: TAG_BIT];
    assign w_hitv0[0] = r_valid[0][w_set0] && (r_tag[0][w_set0] == w_tag0);
    assign w_hitv0[1] = r_valid[1][w_set0] && (r_tag[1][w_set0] == w_tag0);
    assign w_hit0     = |w_hitv0;
    assign w_way0     = w_hitv0[1];
    assign w_word0    = r_data[w_way0][w_set0][w_addr0[2 +: BEAT_BIT]];
    assign w_h0       = w_addr0[1] ? w_word0[31:16] : w_word0[15:0];

    assign w_set1     = w_addr1[LINE_BIT +: SET_BIT];
    assign w_tag1     = w_addr1[31 -: TAG_BIT];
    assign w_hitv1[0] = r_valid[0][w_set1] && (r_tag[0][w_set1] == w_tag1);
    assign w_hitv1[1] = r_valid[1][w_set1] && (r_tag[1][w_set1] == w_tag1);
    assign w_hit1     = |w_hitv1;
    assign w_way1     = w_hitv1[1];
    assign w_word1    = r_data[w_way1][w_set1][w_addr1[2 +: BEAT_BIT]];
    assign w_h1       = w_addr1[1] ? w_word1[31:16] : w_word1[15:0];

    assign w_need1 = (w_h0[1:0] == 2'b11);
    assign w_hit   = w_hit0 && (!w_need1 || w_hit1);

    assign w_miss_line = w_hit0 ? w_addr1[31:LINE_BIT] : w_addr0[31:LINE_BIT];
    assign w_miss_set  = w_miss_line[SET_BIT-1:0];
    assign w_victim    = !r_valid[0][w_miss_set] ? 1'b0 :
                         !r_valid[1][w_miss_set] ? 1'b1 : r_lru[w_miss_set];

    assign w_ref_set = r_line[SET_BIT-1:0];
    assign w_ref_tag = r_line[31-LINE_BIT:SET_BIT];
    assign w_unused  = ^{w_addr0[0], w_addr1[0]};

    assign req_ready     = (r_state == S_IDLE) && rdy_in && !rob_clear_up;
    assign w_accept      = req_valid && req_ready;
    assign mem_req_valid = (r_state == S_REFILL);
    assign mem_req_addr  = {r_line, r_beat, 2'b00};
    assign w_beat_en     = (r_state == S_REFILL) && mem_rdata_valid;
    assign w_last        = w_beat_en && (&r_beat);

    assign resp_valid = r_resp_q && !rob_clear_up;
    assign resp_inst  = r_resp_inst;
    assign resp_is_c  = r_resp_is_c;

    always_comb begin
        w_state_nxt    = r_state;
        w_respond      = 1'b0;
        w_start_refill = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_respond = 1'b1;
                    end else begin
                        w_start_refill = 1'b1;
                        w_state_nxt    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (w_last) begin
                    w_state_nxt = (r_drop || rob_clear_up) ? S_IDLE : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (rob_clear_up) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_respond   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_start_refill = 1'b1;
                    w_state_nxt    = S_REFILL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_valid[0]  <= '0;
            r_valid[1]  <= '0;
            r_lru       <= '0;
            r_addr      <= '0;
            r_line      <= '0;
            r_beat      <= '0;
            r_victim    <= 1'b0;
            r_drop      <= 1'b0;
            r_resp_q    <= 1'b0;
            r_resp_inst <= '0;
            r_resp_is_c <= 1'b0;
        end else if (rdy_in) begin
            r_state  <= w_state_nxt;
            r_resp_q <= w_respond;
            if (w_accept) begin
                r_addr <= req_addr;
            end
            if (w_respond) begin
                r_resp_inst   <= w_need1 ? {w_h1, w_h0} : {16'h0000, w_h0};
                r_resp_is_c   <= !w_need1;
                r_lru[w_set0] <= !w_way0;
                if (w_need1) begin
                    r_lru[w_set1] <= !w_way1;
                end
            end
            if (w_start_refill) begin
                r_line   <= w_miss_line;
                r_beat   <= '0;
                r_victim <= w_victim;
            end
            if (w_beat_en) begin
                r_beat <= r_beat + BEAT_BIT'(1);
            end
            if (w_last) begin
                r_valid[r_victim][w_ref_set] <= 1'b1;
                r_lru[w_ref_set]             <= !r_victim;
            end
            // a flush during refill still installs the line, then drops the fetch
            if ((r_state == S_REFILL) && rob_clear_up) begin
                r_drop <= 1'b1;
            end
            if (w_state_nxt == S_IDLE) begin
                r_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_beat_en) begin
            r_data[r_victim][w_ref_set][r_beat] <= mem_rdata;
        end
        if (rdy_in && w_last) begin
            r_tag[r_victim][w_ref_set] <= w_ref_tag;
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios plus random fetches, checked against
// a line-presence model of a 2-way LRU cache over a fixed memory image.
module tb_icache_assoc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready, resp_valid, resp_is_c, mem_req_valid;
    logic [31:0] resp_inst, mem_req_addr;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    icache_assoc #(.SET_BIT(4), .LINE_BIT(4)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .rob_clear_up(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_is_c(resp_is_c),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory image, 4 KB, aliased above that
    logic [31:0] mem_arr [1024];
    function automatic logic [31:0] memw(input logic [31:0] a);
        return mem_arr[a[11:2]];
    endfunction
    function automatic logic [15:0] memh(input logic [31:0] a);
        logic [31:0] w;
        w = memw(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // model: which lines live in which way, and the LRU bit per set
    bit          m_v   [2][16];
    logic [23:0] m_t   [2][16];
    bit          m_lru [16];
    logic [31:0] q_exp [$];

    task automatic m_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) m_v[w][s] = 0;
        for (int s = 0; s < 16; s++) m_lru[s] = 0;
    endtask

    function automatic int m_find(input logic [31:0] a);
        for (int w = 0; w < 2; w++)
            if (m_v[w][a[7:4]] && m_t[w][a[7:4]] == a[31:8]) return w;
        return -1;
    endfunction

    task automatic m_refill(input logic [31:0] a);
        int s, v;
        s = int'(a[7:4]);
        v = !m_v[0][s] ? 0 : (!m_v[1][s] ? 1 : int'(m_lru[s]));
        m_v[v][s] = 1;
        m_t[v][s] = a[31:8];
        m_lru[s]  = (v == 0);
        for (int b = 0; b < 4; b++) q_exp.push_back({a[31:4], 4'h0} + 32'(4 * b));
    endtask

    task automatic model_fetch(input logic [31:0] a, output logic [31:0] inst,
                               output bit is_c, output int n);
        logic [15:0] h0;
        logic [31:0] a1;
        bit need1;
        n  = 0;
        a1 = a + 32'd2;
        if (m_find(a) < 0) begin m_refill(a); n++; end
        h0    = memh(a);
        need1 = (h0[1:0] == 2'b11);
        if (need1 && m_find(a1) < 0) begin m_refill(a1); n++; end
        m_lru[a[7:4]] = (m_find(a) == 0);
        if (need1) m_lru[a1[7:4]] = (m_find(a1) == 0);
        inst = need1 ? {memh(a1), h0} : {16'h0000, h0};
        is_c = !need1;
    endtask

    // memory controller: fixed latency per word, holds data while rdy is low
    int          mem_lat = 1;
    int          wcnt = 0;
    bit          consumed = 0;
    logic [31:0] q_seen [$];
    always @(posedge clk) begin
        consumed = mem_rdata_valid && rdy && mem_req_valid && rst_n;
        if (consumed) q_seen.push_back(mem_req_addr);
    end
    always @(negedge clk) begin
        if (!(mem_rdata_valid && !consumed && mem_req_valid)) begin
            mem_rdata_valid = 1'b0;
            if (mem_req_valid) begin
                wcnt++;
                if (wcnt >= mem_lat) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = memw(mem_req_addr);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    logic [31:0] q_r_inst [$];
    bit          q_r_c    [$];
    int          q_r_cyc  [$];
    always @(negedge clk) begin
        if (resp_valid) begin
            q_r_inst.push_back(resp_inst);
            q_r_c.push_back(resp_is_c);
            q_r_cyc.push_back(cyc);
        end
        if (mem_req_valid) chk("ready_in_refill", {31'b0, req_ready}, 32'd0);
    end

    task automatic clear_q();
        q_exp.delete(); q_seen.delete();
        q_r_inst.delete(); q_r_c.delete(); q_r_cyc.delete();
    endtask

    task automatic issue(input logic [31:0] a, output int acc, output bit ok);
        int k = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && k < 200) begin @(negedge clk); k++; end
        ok = req_ready;
        acc = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: addr %h never accepted", a);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic finish_check(input int acc, input int n, input int lat, input int extra,
                                input logic [31:0] e_inst, input bit e_c, input bit exp_resp);
        int k = 0;
        int exp_lat;
        if (exp_resp)
            while (q_r_inst.size() == 0 && k < 600) begin @(posedge clk); #2; k++; end
        else
            while (mem_req_valid && k < 600) begin @(posedge clk); #2; k++; end
        repeat (5) @(posedge clk);
        #2;
        chk("resp_count", 32'(q_r_inst.size()), exp_resp ? 32'd1 : 32'd0);
        if (exp_resp && q_r_inst.size() > 0) begin
            exp_lat = (n == 0) ? 1 : 1 + n * (4 * lat + 1) + extra;
            chk("resp_inst", q_r_inst[0], e_inst);
            chk("resp_is_c", {31'b0, q_r_c[0]}, {31'b0, e_c});
            chk("latency", 32'(q_r_cyc[0] - acc + 1), 32'(exp_lat));
        end
        chk("mem_reads", 32'(q_seen.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_seen.size(); i++)
            chk("mem_addr", q_seen[i], q_exp[i]);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int lat, input bit lit_en,
                            input logic [31:0] lit_inst, input bit lit_c,
                            input int lit_lines, input logic [31:0] lit_base);
        logic [31:0] e_inst;
        bit e_c, ok;
        int n, acc;
        clear_q();
        mem_lat = lat;
        model_fetch(a, e_inst, e_c, n);
        issue(a, acc, ok);
        if (!ok) return;
        finish_check(acc, n, lat, 0, e_inst, e_c, 1'b1);
        if (lit_en && q_r_inst.size() > 0) begin
            chk("lit_inst", q_r_inst[0], lit_inst);
            chk("lit_is_c", {31'b0, q_r_c[0]}, {31'b0, lit_c});
        end
        if (lit_lines >= 0) begin
            chk("lit_lines", 32'(q_seen.size()), 32'(4 * lit_lines));
            if (lit_lines > 0 && q_seen.size() > 0) chk("lit_base", q_seen[0], lit_base);
        end
    endtask

    initial begin
        logic [31:0] e_inst, sa;
        bit e_c, ok;
        int n, acc, k, ns;

        for (int i = 0; i < 1024; i++) mem_arr[i] = $urandom;
        mem_arr[32'h100 >> 2] = 32'h0050_0093;
        mem_arr[32'h104 >> 2] = 32'h4505_0001;
        mem_arr[32'h10C >> 2] = 32'h0513_0001;
        mem_arr[32'h110 >> 2] = 32'h1111_ABCD;
        m_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_inst", resp_inst, 32'd0);
        chk("rst_resp_is_c", {31'b0, resp_is_c}, 32'd0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        rst_n = 1'b1;

        do_fetch(32'h100, 2, 1, 32'h0050_0093, 0, 1, 32'h100);
        do_fetch(32'h100, 1, 1, 32'h0050_0093, 0, 0, 0);
        do_fetch(32'h106, 1, 1, 32'h0000_4505, 1, 0, 0);
        do_fetch(32'h10E, 1, 1, 32'hABCD_0513, 0, 1, 32'h110);

        do_fetch(32'h000, 1, 0, 0, 0, 1, 32'h000);
        do_fetch(32'h100, 1, 1, 32'h0050_0093, 0, 0, 0);
        do_fetch(32'h200, 1, 0, 0, 0, 1, 32'h200);
        do_fetch(32'h100, 1, 1, 32'h0050_0093, 0, 0, 0);
        do_fetch(32'h000, 1, 0, 0, 0, 1, 32'h000);

        // flush during the second beat: line installed, no response
        clear_q();
        mem_lat = 2;
        m_refill(32'h300);
        issue(32'h300, acc, ok);
        k = 0;
        while (q_seen.size() < 1 && k < 200) begin @(posedge clk); #1; k++; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        finish_check(acc, 1, 2, 0, 0, 0, 1'b0);
        do_fetch(32'h300, 1, 0, 0, 0, 0, 0);

        // three-cycle stall with data held valid
        clear_q();
        mem_lat = 1;
        model_fetch(32'h410, e_inst, e_c, n);
        issue(32'h410, acc, ok);
        k = 0;
        while (q_seen.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
        @(negedge clk); #1;
        chk("stall_data_valid", {31'b0, mem_rdata_valid}, 32'd1);
        rdy = 1'b0;
        ns = q_seen.size();
        sa = mem_req_addr;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_beats", 32'(q_seen.size()), 32'(ns));
        chk("stall_addr", mem_req_addr, sa);
        rdy = 1'b1;
        finish_check(acc, n, 1, 3, e_inst, e_c, 1'b1);
        for (int h = 0; h < 7; h++) do_fetch(32'h410 + 32'(2 * h), 1, 0, 0, 0, -1, 0);

        // reset in the middle of a burst
        clear_q();
        mem_lat = 2;
        issue(32'h520, acc, ok);
        k = 0;
        while (q_seen.size() < 1 && k < 200) begin @(posedge clk); #1; k++; end
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("midrst_resp_inst", resp_inst, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        do_fetch(32'h100, 1, 1, 32'h0050_0093, 0, 1, 32'h100);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 1) == 0) a = 32'h100 + 32'($urandom_range(0, 63) * 2);
            else                            a = 32'($urandom_range(0, 1023) * 2);
            do_fetch(a, $urandom_range(1, 3), 0, 0, 0, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
